serial_adder_ctrl: RTL and testbench

//  Bit-serial add/subtract controller for the calculator datapath. It shares one

---
 rtl/calc_pkg.sv | 13 +
 rtl/FullAdder.sv | 13 +
 rtl/serial_adder_ctrl.sv | 110 +++++++++++
 tb/tb_serial_adder_ctrl.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared calculator definitions: operation codes and the serial adder controller states.
package calc_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/FullAdder.sv
// One-bit full adder cell shared by the bit-serial datapath.
module FullAdder (
  input  logic i_A,
  input  logic i_B,
  input  logic i_C,
  output logic o_sum,
  output logic o_carry
);

  assign o_sum   = i_A ^ i_B ^ i_C;
  assign o_carry = (i_A & i_B) | (i_C & (i_A ^ i_B));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one FullAdder reused LSB-first over W cycles,
// with busy/done handshake and registered result, carry and signed-overflow flags.
module serial_adder_ctrl
  import calc_pkg::*;
#(
  parameter  int unsigned W     = 8,
  localparam int unsigned CNT_W = $clog2(W)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_start,
  input  logic         i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_busy,
  output logic         o_done,
  output logic [W-1:0] o_result,
  output logic         o_carry,
  output logic         o_overflow
);

  state_t state, state_nxt;

  logic [W-1:0]     a_sr, b_sr;
  logic [W-2:0]     res_sr;
  logic [W-1:0]     res_next;
  logic [CNT_W-1:0] cnt;
  logic             carry_ff;
  logic             fa_sum, fa_carry;
  logic             load, step, last;

  FullAdder u_fa (
    .i_A     (a_sr[0]),
    .i_B     (b_sr[0]),
    .i_C     (carry_ff),
    .o_sum   (fa_sum),
    .o_carry (fa_carry)
  );

  assign last = (cnt == CNT_W'(W - 1));
  // Only the upper W-1 partial-sum bits are stored; the final bit joins them on the last step.
  assign res_next = {fa_sum, res_sr};

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    o_busy    = 1'b0;
    o_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        o_busy = 1'b1;
        step   = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done = 1'b1;
        if (i_start) begin
          load      = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      carry_ff   <= 1'b0;
      o_result   <= '0;
      o_carry    <= 1'b0;
      o_overflow <= 1'b0;
    end else if (load) begin
      a_sr     <= i_a;
      b_sr     <= (i_op == OP_SUB) ? ~i_b : i_b;
      carry_ff <= (i_op == OP_SUB);
      cnt      <= '0;
    end else if (step) begin
      a_sr     <= a_sr >> 1;
      b_sr     <= b_sr >> 1;
      res_sr   <= res_next[W-1:1];
      carry_ff <= fa_carry;
      cnt      <= cnt + 1'b1;
      // carry_ff holds the carry into the MSB during the last step
      if (last) begin
        o_result   <= res_next;
        o_carry    <= fa_carry;
        o_overflow <= carry_ff ^ fa_carry;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed vector table, corner sequences,
// and back-to-back random pairs against an arithmetic reference model.
module tb_serial_adder_ctrl;
  import calc_pkg::*;

  localparam int unsigned W = 8;
  localparam int unsigned TMO = 4 * W;

  logic         clk = 1'b0;
  logic         reset, start, op;
  logic [W-1:0] a, b, result;
  logic         busy, done, carry, ovf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.W(W)) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_start    (start),
    .i_op       (op),
    .i_a        (a),
    .i_b        (b),
    .o_busy     (busy),
    .o_done     (done),
    .o_result   (result),
    .o_carry    (carry),
    .o_overflow (ovf)
  );

  typedef struct {
    logic         op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         carry;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: unsigned sum/difference for result and carry, signed range test for overflow.
  function automatic void ref_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 output logic [W-1:0] r, output logic c, output logic v);
    int unsigned usum;
    int          sx, sy, ssum;
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (o == OP_SUB) begin
      usum = int'(x) + (2 ** W) - int'(y);
      ssum = sx - sy;
    end else begin
      usum = int'(x) + int'(y);
      ssum = sx + sy;
    end
    r = W'(usum % (2 ** W));
    c = (usum >= 2 ** W);
    v = (ssum > (2 ** (W - 1)) - 1) || (ssum < -(2 ** (W - 1)));
  endfunction

  task automatic scramble_inputs();
    a  = W'($urandom);
    b  = W'($urandom);
    op = 1'($urandom);
  endtask

  task automatic run_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [W-1:0] r, output logic c, output logic v,
                        output int unsigned lat, output int unsigned nbusy);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    scramble_inputs();
    lat = 1; nbusy = 0;
    while (!done && lat < TMO) begin
      if (busy) nbusy++;
      @(negedge clk);
      lat++;
    end
    r = result; c = carry; v = ovf;
  endtask

  initial begin
    logic [W-1:0] r, er, er2;
    logic         c, v, ec, ev, ec2, ev2, o1, o2;
    logic [W-1:0] x1, y1, x2, y2;
    int unsigned  lat, nbusy, ndone;

    vecs[0] = '{op: OP_ADD, a: 8'd100, b: 8'd27, res: 8'd127, carry: 1'b0, ovf: 1'b0};
    vecs[1] = '{op: OP_ADD, a: 8'hFF,  b: 8'h01, res: 8'h00,  carry: 1'b1, ovf: 1'b0};
    vecs[2] = '{op: OP_ADD, a: 8'h7F,  b: 8'h01, res: 8'h80,  carry: 1'b0, ovf: 1'b1};
    vecs[3] = '{op: OP_SUB, a: 8'h05,  b: 8'h07, res: 8'hFE,  carry: 1'b0, ovf: 1'b0};
    vecs[4] = '{op: OP_SUB, a: 8'h80,  b: 8'h01, res: 8'h7F,  carry: 1'b1, ovf: 1'b1};
    vecs[5] = '{op: OP_SUB, a: 8'h33,  b: 8'h33, res: 8'h00,  carry: 1'b1, ovf: 1'b0};
    vecs[6] = '{op: OP_ADD, a: 8'h80,  b: 8'h80, res: 8'h00,  carry: 1'b1, ovf: 1'b1};
    vecs[7] = '{op: OP_SUB, a: 8'h00,  b: 8'h80, res: 8'h80,  carry: 1'b0, ovf: 1'b1};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy",   busy,   0);
    check("reset_done",   done,   0);
    check("reset_result", result, 0);
    check("reset_carry",  carry,  0);
    check("reset_ovf",    ovf,    0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, c, v, lat, nbusy);
      check($sformatf("vec%0d_latency", i), lat, W + 1);
      check($sformatf("vec%0d_busy_cycles", i), nbusy, W);
      check($sformatf("vec%0d_busy_in_done", i), busy, 0);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_carry", i), c, vecs[i].carry);
      check($sformatf("vec%0d_ovf", i), v, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("vec%0d_done_one_cycle", i), done, 0);
    end

    // Start pulse during RUN bit 3 must be ignored.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 8'h12; b = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    start = 1'b1; op = OP_SUB; a = 8'hFF; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; r = '0;
    for (int k = 0; k < 3 * W; k++) begin
      if (done) begin
        ndone++;
        r = result;
      end
      @(negedge clk);
    end
    check("ignore_start_done_count", ndone, 1);
    check("ignore_start_result", r, 8'h46);

    // Reset during RUN bit 3 aborts with no done pulse.
    @(negedge clk);
    start = 1'b1; op = OP_ADD; a = 8'h40; b = 8'h41;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy",   busy,   0);
    check("abort_done",   done,   0);
    check("abort_result", result, 0);
    check("abort_carry",  carry,  0);
    check("abort_ovf",    ovf,    0);
    ndone = 0;
    for (int k = 0; k < 2 * W; k++) begin
      if (done) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", ndone, 0);
    run_op(OP_ADD, 8'd1, 8'd1, r, c, v, lat, nbusy);
    check("after_abort_latency", lat, W + 1);
    check("after_abort_result", r, 8'd2);
    check("after_abort_carry", c, 0);
    check("after_abort_ovf", v, 0);

    // Back-to-back random pairs: start held high through the DONE cycle.
    for (int p = 0; p < 1000; p++) begin
      o1 = 1'($urandom); x1 = W'($urandom); y1 = W'($urandom);
      o2 = 1'($urandom); x2 = W'($urandom); y2 = W'($urandom);
      ref_op(o1, x1, y1, er, ec, ev);
      ref_op(o2, x2, y2, er2, ec2, ev2);
      @(negedge clk);
      start = 1'b1; op = o1; a = x1; b = y1;
      @(negedge clk);
      op = o2; a = x2; b = y2;
      lat = 1;
      while (!done && lat < TMO) begin
        @(negedge clk);
        lat++;
      end
      check("b2b_op1_latency", lat, W + 1);
      check("b2b_op1_result", result, er);
      check("b2b_op1_carry", carry, ec);
      check("b2b_op1_ovf", ovf, ev);
      @(negedge clk);
      start = 1'b0;
      scramble_inputs();
      check("b2b_op2_accepted", busy, 1);
      lat = 1;
      while (!done && lat < TMO) begin
        @(negedge clk);
        lat++;
      end
      check("b2b_op2_latency", lat, W + 1);
      check("b2b_op2_result", result, er2);
      check("b2b_op2_carry", carry, ec2);
      check("b2b_op2_ovf", ovf, ev2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
